bitstream_serializer: RTL and testbench

Configuration bitstream transmitter. It accepts a `CFG_SIZE`-bit parallel configuration word through a valid/ready load handshake. It then shifts the word out one bit per accepted cycle, MSB first, on a single-bit serial link. The link is the feeding side of the configuration-load path and pairs with the bitstream deserializer.

---
 rtl/cfg_stream_pkg.sv | 15 +
 rtl/bitstream_serializer.sv | 57 +++++
 tb/tb_bitstream_serializer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/cfg_stream_pkg.sv
// Shared definitions for the configuration bitstream link (serializer and deserializer).
package cfg_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } cfg_state_t;

  // Counter width able to hold the value n itself (n bits sent => count reaches n).
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/bitstream_serializer.sv
// Configuration bitstream transmitter: loads a CFG_SIZE-bit word, shifts it out MSB first
// with valid/ready flow control on the serial side, then pulses CfgDone for one cycle.
module bitstream_serializer
  import cfg_stream_pkg::*;
#(
  parameter int CFG_SIZE = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CFG_SIZE-1:0] ParallelIn,
  input  logic                LoadValid,
  output logic                LoadReady,
  input  logic                StreamReady,
  output logic                SerialOut,
  output logic                StreamValid,
  output logic                CfgDone,
  output logic                Busy
);

  localparam int CW = cnt_width(CFG_SIZE);
  localparam logic [CW-1:0] LAST_BIT = CW'(CFG_SIZE - 1);

  logic [CFG_SIZE-1:0] ShiftReg;
  logic [CW-1:0]       BitCount;
  cfg_state_t          State;

  always_ff @(posedge clk) begin
    if (!rst) begin
      State    <= IDLE;
      ShiftReg <= '0;
      BitCount <= '0;
    end else begin
      case (State)
        IDLE: if (LoadValid) begin
          ShiftReg <= ParallelIn;
          BitCount <= '0;
          State    <= SHIFT;
        end
        // A stalled cycle holds everything so the presented bit stays stable.
        SHIFT: if (StreamReady) begin
          ShiftReg <= {ShiftReg[CFG_SIZE-2:0], 1'b0};
          BitCount <= BitCount + CW'(1);
          if (BitCount == LAST_BIT) State <= DONE;
        end
        DONE:    State <= IDLE;
        default: State <= IDLE;
      endcase
    end
  end

  assign LoadReady   = (State == IDLE);
  assign StreamValid = (State == SHIFT);
  assign SerialOut   = StreamValid ? ShiftReg[CFG_SIZE-1] : 1'b0;
  assign CfgDone     = (State == DONE);
  assign Busy        = (State != IDLE);

endmodule

// File: tb/tb_bitstream_serializer.sv
// Directed bench: 8-bit instance for protocol cases, 100-bit instance looped into a
// behavioural left-shifting receiver.
module tb_bitstream_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic [7:0] pin8 = '0;
  logic lv8 = 1'b0, sr8 = 1'b1;
  logic lr8, so8, sv8, cd8, bz8;

  bitstream_serializer #(.CFG_SIZE(8)) u_dut8 (
    .clk(clk), .rst(rst), .ParallelIn(pin8), .LoadValid(lv8), .LoadReady(lr8),
    .StreamReady(sr8), .SerialOut(so8), .StreamValid(sv8), .CfgDone(cd8), .Busy(bz8)
  );

  // 100-bit instance, direct link (StreamReady tied high)
  logic [99:0] pinb = '0;
  logic lvb = 1'b0;
  logic srb = 1'b1;
  logic lrb, sob, svb, cdb, bzb;

  bitstream_serializer #(.CFG_SIZE(100)) u_dut100 (
    .clk(clk), .rst(rst), .ParallelIn(pinb), .LoadValid(lvb), .LoadReady(lrb),
    .StreamReady(srb), .SerialOut(sob), .StreamValid(svb), .CfgDone(cdb), .Busy(bzb)
  );

  // Receiver model: left-shift accepted bits, publish a word every 100 bits
  logic [99:0] rx_sh, rx_last;
  int rx_cnt, rx_words;
  int cyc_cnt = 0;

  always @(posedge clk) begin
    cyc_cnt <= cyc_cnt + 1;
    if (!rst) begin
      rx_sh <= '0; rx_last <= '0; rx_cnt <= 0; rx_words <= 0;
    end else if (svb && srb) begin
      rx_sh <= {rx_sh[98:0], sob};
      if (rx_cnt == 99) begin
        rx_cnt   <= 0;
        rx_last  <= {rx_sh[98:0], sob};
        rx_words <= rx_words + 1;
      end else begin
        rx_cnt <= rx_cnt + 1;
      end
    end
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Load w into the 8-bit DUT, stall stall_n cycles once nb==stall_at bits were accepted,
  // optionally drive a competing load mid-stream. Expected CfgDone cycle relative to load.
  task automatic send8(input string tag, input logic [7:0] w, input int stall_at,
                       input int stall_n, input bit inj, input int exp_done);
    int cyc, nb, st;
    logic [7:0] got;
    bit done, lr_seen, rdy, bexp;
    cyc = 0; nb = 0; st = 0; got = '0; done = 0; lr_seen = 0;
    pin8 = w; lv8 = 1'b1; sr8 = 1'b1;
    @(negedge clk);
    lv8 = 1'b0; cyc = 1;
    while (!done && cyc < 40) begin
      rdy = !(nb == stall_at && st < stall_n);
      sr8 = rdy;
      bexp = (nb < 8) ? w[7-nb] : 1'b0;
      if (inj && nb >= 3) begin lv8 = 1'b1; pin8 = 8'h00; end
      if (lr8) lr_seen = 1;
      if (cd8) begin
        lv8 = 1'b0;
        chk({tag, " done_cycle"}, 128'(cyc), 128'(exp_done));
        done = 1;
      end else if (!sv8) begin
        chk({tag, " stream_valid"}, 128'(sv8), 128'(1));
      end else if (rdy) begin
        chk({tag, " bit"}, 128'(so8), 128'(bexp));
        got = {got[6:0], so8};
        nb++;
      end else begin
        chk({tag, " stall_bit"}, 128'({sv8, so8}), 128'({1'b1, bexp}));
        st++;
      end
      @(negedge clk);
      cyc++;
    end
    sr8 = 1'b1; lv8 = 1'b0;
    if (!done) chk({tag, " timeout"}, 128'(0), 128'(1));
    chk({tag, " word"}, 128'(got), 128'(w));
    chk({tag, " nbits"}, 128'(nb), 128'(8));
    chk({tag, " ready_low_during_xfer"}, 128'(lr_seen), 128'(0));
    chk({tag, " ready_back"}, 128'({lr8, cd8, bz8}), 128'(3'b100));
  endtask

  initial begin
    logic [99:0] words [3];
    int t_load [3];
    int guard;
    bit cd_seen;

    // Reset state
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs8", 128'({lr8, sv8, so8, cd8, bz8}), 128'(5'b10000));
    chk("reset_outputs100", 128'({lrb, svb, sob, cdb, bzb}), 128'(5'b10000));
    rst = 1'b1;
    @(negedge clk);

    // A5 basic, F0 with 3-cycle stall after 2 bits, FF with ignored load of 00
    send8("basic_a5", 8'hA5, -1, 0, 0, 9);
    send8("stall_f0", 8'hF0, 2, 3, 0, 12);
    send8("ignore_ff", 8'hFF, -1, 0, 1, 9);
    @(negedge clk);
    chk("ignore_no_second_xfer", 128'({sv8, bz8, lr8}), 128'(3'b001));

    // Mid-stream reset after 4 bits of 3C (0,0,1,1)
    pin8 = 8'h3C; lv8 = 1'b1;
    @(negedge clk);
    lv8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("midrst_bit", 128'({sv8, so8}), 128'({1'b1, (i >= 2)}));
      @(negedge clk);
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("midrst_outputs", 128'({sv8, so8, lr8, cd8, bz8}), 128'(5'b00100));
    cd_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (cd8 || sv8) cd_seen = 1;
      @(negedge clk);
    end
    chk("midrst_no_done", 128'(cd_seen), 128'(0));
    send8("after_rst_81", 8'h81, -1, 0, 0, 9);

    // Loopback, 100-bit back-to-back loads at minimum spacing
    for (int w = 0; w < 3; w++)
      for (int b = 0; b < 100; b++) words[w][b] = 1'($urandom_range(0, 1));
    for (int w = 0; w < 3; w++) begin
      pinb = words[w]; lvb = 1'b1;
      guard = 0;
      while (!lrb && guard < 200) begin @(negedge clk); guard++; end
      if (guard >= 200) chk("loop_ready_timeout", 128'(0), 128'(1));
      t_load[w] = cyc_cnt;
      @(negedge clk);
      if (w == 2) lvb = 1'b0;
      guard = 0;
      while (rx_words < w + 1 && guard < 200) begin @(negedge clk); guard++; end
      chk("loop_done_count", 128'(rx_words), 128'(w + 1));
      chk("loop_word", 128'(rx_last), 128'(words[w]));
      if (w > 0) chk("loop_spacing", 128'(t_load[w] - t_load[w-1]), 128'(102));
    end
    lvb = 1'b0;
    repeat (4) @(negedge clk);
    chk("loop_idle_end", 128'({lrb, svb, rx_words}), {95'd0, 1'b1, 1'b0, 32'd3});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
